// File: rtl/rv32i_fetch_decode_exec.sv
// Fetch engine, combinational decoder and execute datapath of the multi-cycle RV32I core.
// The fetch FSM pulls one instruction from the shared SDRAM read port; execute is purely combinational.
module rv32i_fetch_decode_exec #(
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        fetch_req,
  output logic        fetch_fin,
  output logic        sdram_rd_req,
  output logic [31:0] sdram_rd_addr,
  input  logic        sdram_rd_fin,
  input  logic [31:0] sdram_rd_data,
  output logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  input  logic [31:0] rrs1,
  input  logic [31:0] rrs2,
  input  logic        exec_req,
  output logic [31:0] result,
  output logic [31:0] next_pc,
  output logic        wr_mem,
  output logic [31:0] wr_mem_addr,
  output logic [31:0] wr_mem_data,
  output logic        rd_mem,
  output logic [31:0] rd_mem_addr,
  output logic        wr_regfile
);

  typedef enum logic [1:0] {
    F_IDLE,
    F_WAIT,
    F_DONE
  } fetch_state_t;

  typedef enum logic [4:0] {
    OPC_LOAD   = 5'b00000,
    OPC_OP_IMM = 5'b00100,
    OPC_AUIPC  = 5'b00101,
    OPC_STORE  = 5'b01000,
    OPC_OP     = 5'b01100,
    OPC_LUI    = 5'b01101,
    OPC_BRANCH = 5'b11000,
    OPC_JALR   = 5'b11001,
    OPC_JAL    = 5'b11011
  } opcode_t;

  fetch_state_t state;
  logic         fetch_abort;

  opcode_t      opcode;
  logic [2:0]   funct3;
  logic [31:0]  imm;
  logic [31:0]  alu_b;
  logic [4:0]   shamt;
  logic [31:0]  alu_out;
  logic [31:0]  pc_plus4;
  logic [31:0]  pc_rel;
  logic [31:0]  mem_addr;
  logic         branch_taken;
  logic         writes_rd;
  logic         is_load;
  logic         is_store;

  // A fetch abandoned by the requester still has to drain the SDRAM read,
  // so the abort is remembered and the capture completes without fetch_fin.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= F_IDLE;
      instr         <= RESET_INSTR;
      fetch_fin     <= 1'b0;
      sdram_rd_req  <= 1'b0;
      sdram_rd_addr <= 32'd0;
      fetch_abort   <= 1'b0;
    end else begin
      case (state)
        F_IDLE: begin
          if (fetch_req) begin
            sdram_rd_addr <= pc;
            sdram_rd_req  <= 1'b1;
            fetch_abort   <= 1'b0;
            state         <= F_WAIT;
          end
        end
        F_WAIT: begin
          if (sdram_rd_fin) begin
            instr        <= sdram_rd_data;
            sdram_rd_req <= 1'b0;
            if (fetch_req && !fetch_abort) begin
              fetch_fin <= 1'b1;
              state     <= F_DONE;
            end else begin
              state <= F_IDLE;
            end
          end else if (!fetch_req) begin
            fetch_abort <= 1'b1;
          end
        end
        F_DONE: begin
          if (!fetch_req) begin
            fetch_fin <= 1'b0;
            state     <= F_IDLE;
          end
        end
        default: begin
          fetch_fin    <= 1'b0;
          sdram_rd_req <= 1'b0;
          state        <= F_IDLE;
        end
      endcase
    end
  end

  assign opcode = opcode_t'(instr[6:2]);
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  // Immediate selection; formats not listed (R-type, SYSTEM, ...) yield zero.
  always_comb begin
    imm = 32'd0;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'd0};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = 32'd0;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;
  assign pc_rel   = pc + imm;
  assign mem_addr = rrs1 + imm;

  // SUB exists only for register-register ops; funct7[5] on OP-IMM is the SRAI marker.
  always_comb begin
    alu_b   = (opcode == OPC_OP) ? rrs2 : imm;
    shamt   = alu_b[4:0];
    alu_out = 32'd0;
    case (funct3)
      3'b000: alu_out = (opcode == OPC_OP && instr[30]) ? (rrs1 - alu_b) : (rrs1 + alu_b);
      3'b001: alu_out = rrs1 << shamt;
      3'b010: alu_out = {31'd0, $signed(rrs1) < $signed(alu_b)};
      3'b011: alu_out = {31'd0, rrs1 < alu_b};
      3'b100: alu_out = rrs1 ^ alu_b;
      3'b101: begin
        if (instr[30]) alu_out = $signed(rrs1) >>> shamt;
        else           alu_out = rrs1 >> shamt;
      end
      3'b110: alu_out = rrs1 | alu_b;
      3'b111: alu_out = rrs1 & alu_b;
      default: alu_out = 32'd0;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000: branch_taken = (rrs1 == rrs2);
      3'b001: branch_taken = (rrs1 != rrs2);
      3'b100: branch_taken = ($signed(rrs1) < $signed(rrs2));
      3'b101: branch_taken = ($signed(rrs1) >= $signed(rrs2));
      3'b110: branch_taken = (rrs1 < rrs2);
      3'b111: branch_taken = (rrs1 >= rrs2);
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    result    = 32'd0;
    next_pc   = pc_plus4;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        result    = alu_out;
        writes_rd = 1'b1;
      end
      OPC_LUI: begin
        result    = imm;
        writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        result    = pc_rel;
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        result    = pc_plus4;
        next_pc   = pc_rel;
        writes_rd = 1'b1;
      end
      OPC_JALR: begin
        result    = pc_plus4;
        next_pc   = {mem_addr[31:1], 1'b0};
        writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        if (branch_taken) next_pc = pc_rel;
      end
      OPC_LOAD: begin
        is_load   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_STORE: begin
        is_store = 1'b1;
      end
      default: begin
        result = 32'd0;
      end
    endcase
  end

  // Addresses and store data stay valid after exec_req drops; only the strobes are qualified.
  assign wr_regfile  = writes_rd && (rd != 5'd0);
  assign wr_mem      = exec_req && is_store;
  assign rd_mem      = exec_req && is_load;
  assign wr_mem_addr = mem_addr;
  assign rd_mem_addr = mem_addr;
  assign wr_mem_data = rrs2;

endmodule

// File: tb/tb_rv32i_fetch_decode_exec.sv
// Bench for rv32i_fetch_decode_exec: directed fetch/exec scenarios followed by random
// instructions checked against an arithmetic reference of the RV32I rules.
module tb_rv32i_fetch_decode_exec;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        fetch_req;
  logic        fetch_fin;
  logic        sdram_rd_req;
  logic [31:0] sdram_rd_addr;
  logic        sdram_rd_fin;
  logic [31:0] sdram_rd_data;
  logic [31:0] instr;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rrs1, rrs2;
  logic        exec_req;
  logic [31:0] result, next_pc;
  logic        wr_mem;
  logic [31:0] wr_mem_addr, wr_mem_data;
  logic        rd_mem;
  logic [31:0] rd_mem_addr;
  logic        wr_regfile;

  int n_cmp  = 0;
  int n_fail = 0;

  rv32i_fetch_decode_exec dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .fetch_req     (fetch_req),
    .fetch_fin     (fetch_fin),
    .sdram_rd_req  (sdram_rd_req),
    .sdram_rd_addr (sdram_rd_addr),
    .sdram_rd_fin  (sdram_rd_fin),
    .sdram_rd_data (sdram_rd_data),
    .instr         (instr),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd            (rd),
    .rrs1          (rrs1),
    .rrs2          (rrs2),
    .exec_req      (exec_req),
    .result        (result),
    .next_pc       (next_pc),
    .wr_mem        (wr_mem),
    .wr_mem_addr   (wr_mem_addr),
    .wr_mem_data   (wr_mem_data),
    .rd_mem        (rd_mem),
    .rd_mem_addr   (rd_mem_addr),
    .wr_regfile    (wr_regfile)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] ins, input logic [31:0] a,
                                          input logic [31:0] b, input bit is_op);
    logic [31:0] r;
    r = 32'd0;
    case (ins[14:12])
      3'd0: r = (is_op && ins[30]) ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        if (ins[30]) r = $signed(a) >>> b[4:0];
        else         r = a >> b[4:0];
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Immediates are rebuilt as weighted sums of instruction fields.
  task automatic ref_exec(input logic [31:0] ins, input logic [31:0] pcv, input logic [31:0] a,
                          input logic [31:0] b, input logic ex,
                          output logic [31:0] res, output logic [31:0] npc, output logic [31:0] maddr,
                          output logic wreg, output logic wm, output logic rm);
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    bit writes;
    i_imm = 32'($signed(ins[31:20]));
    s_imm = 32'($signed(ins[31:25])) * 32 + 32'(ins[11:7]);
    b_imm = 32'($signed({ins[31], ins[7]})) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
    u_imm = ins & 32'hFFFFF000;
    j_imm = 32'($signed(ins[31:31])) * 32'h0010_0000 + 32'(ins[19:12]) * 4096
          + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
    res = 32'd0; npc = pcv + 32'd4; maddr = 32'd0; writes = 1'b0; wm = 1'b0; rm = 1'b0;
    case (ins[6:2])
      5'h0C: begin res = ref_alu(ins, a, b, 1'b1); writes = 1'b1; end
      5'h04: begin res = ref_alu(ins, a, i_imm, 1'b0); writes = 1'b1; end
      5'h0D: begin res = u_imm; writes = 1'b1; end
      5'h05: begin res = pcv + u_imm; writes = 1'b1; end
      5'h1B: begin res = pcv + 32'd4; npc = pcv + j_imm; writes = 1'b1; end
      5'h19: begin res = pcv + 32'd4; npc = (a + i_imm) & 32'hFFFFFFFE; writes = 1'b1; end
      5'h18: if (ref_taken(ins[14:12], a, b)) npc = pcv + b_imm;
      5'h00: begin maddr = a + i_imm; rm = ex; writes = 1'b1; end
      5'h08: begin maddr = a + s_imm; wm = ex; end
      default: ;
    endcase
    wreg = writes && (ins[11:7] != 5'd0);
  endtask

  // Runs one complete fetch handshake, returning ins from SDRAM after delay idle cycles.
  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pcv, input int delay);
    int guard;
    pc = pcv;
    fetch_req = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!sdram_rd_req && guard < 20);
    chk("rd_req_rise", 32'(sdram_rd_req), 32'd1);
    chk("rd_addr", sdram_rd_addr, pcv);
    repeat (delay) @(negedge clk);
    chk("fin_before", 32'(fetch_fin), 32'd0);
    sdram_rd_fin  = 1'b1;
    sdram_rd_data = ins;
    @(negedge clk);
    sdram_rd_fin  = 1'b0;
    sdram_rd_data = $urandom;
    chk("fetch_fin", 32'(fetch_fin), 32'd1);
    chk("rd_req_fall", 32'(sdram_rd_req), 32'd0);
    chk("instr", instr, ins);
    @(negedge clk);
    chk("fin_hold", 32'(fetch_fin), 32'd1);
    fetch_req = 1'b0;
    @(negedge clk);
    chk("fin_drop", 32'(fetch_fin), 32'd0);
  endtask

  // Drives random operands and compares every execute output with the reference.
  task automatic checkOutput(input logic [31:0] ins, input logic [31:0] pcv);
    logic [31:0] a, b, e_res, e_npc, e_addr;
    logic e_wreg, e_wm, e_rm, ex;
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
    ex = 1'($urandom_range(0, 1));
    rrs1 = a; rrs2 = b; exec_req = ex; pc = pcv;
    #1;
    ref_exec(ins, pcv, a, b, ex, e_res, e_npc, e_addr, e_wreg, e_wm, e_rm);
    chk("rs1", 32'(rs1), 32'(ins[19:15]));
    chk("rs2", 32'(rs2), 32'(ins[24:20]));
    chk("rd", 32'(rd), 32'(ins[11:7]));
    chk("result", result, e_res);
    chk("next_pc", next_pc, e_npc);
    chk("wr_regfile", 32'(wr_regfile), 32'(e_wreg));
    chk("wr_mem", 32'(wr_mem), 32'(e_wm));
    chk("rd_mem", 32'(rd_mem), 32'(e_rm));
    if (ins[6:2] == 5'h08) begin
      chk("wr_mem_addr", wr_mem_addr, e_addr);
      chk("wr_mem_data", wr_mem_data, b);
    end
    if (ins[6:2] == 5'h00) chk("rd_mem_addr", rd_mem_addr, e_addr);
    exec_req = ~ex;
    #1;
    ref_exec(ins, pcv, a, b, ~ex, e_res, e_npc, e_addr, e_wreg, e_wm, e_rm);
    chk("wr_mem_flip", 32'(wr_mem), 32'(e_wm));
    chk("rd_mem_flip", 32'(rd_mem), 32'(e_rm));
  endtask

  logic [7:0] opc_table [11] = '{8'h03, 8'h13, 8'h17, 8'h23, 8'h33, 8'h37,
                                 8'h63, 8'h67, 8'h6F, 8'h73, 8'h0F};

  initial begin
    logic [31:0] r, ins, pcv;
    reset = 1'b0; pc = 32'd0; fetch_req = 1'b0; sdram_rd_fin = 1'b0; sdram_rd_data = 32'd0;
    rrs1 = 32'd0; rrs2 = 32'd0; exec_req = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_instr", instr, 32'h00000013);
    chk("rst_fin", 32'(fetch_fin), 32'd0);
    chk("rst_rd_req", 32'(sdram_rd_req), 32'd0);
    chk("rst_rd_addr", sdram_rd_addr, 32'd0);
    chk("rst_wr_mem", 32'(wr_mem), 32'd0);
    chk("rst_rd_mem", 32'(rd_mem), 32'd0);
    reset = 1'b1;
    exec_req = 1'b0;
    @(negedge clk);

    applyStimulus(32'h00500093, 32'h40, 3);
    rrs1 = 32'd0; #1;
    chk("addi_rd", 32'(rd), 32'd1);
    chk("addi_result", result, 32'd5);
    chk("addi_wr_regfile", 32'(wr_regfile), 32'd1);

    applyStimulus(32'h402081B3, 32'h44, 0);
    rrs1 = 32'd7; rrs2 = 32'd9; #1;
    chk("sub_result", result, 32'hFFFFFFFE);
    applyStimulus(32'h4020D1B3, 32'h48, 1);
    rrs1 = 32'h80000000; rrs2 = 32'd4; #1;
    chk("sra_result", result, 32'hF8000000);

    applyStimulus(32'hFE208CE3, 32'h100, 2);
    rrs1 = 32'd3; rrs2 = 32'd3; #1;
    chk("beq_taken", next_pc, 32'hF8);
    chk("beq_wr_regfile", 32'(wr_regfile), 32'd0);
    rrs2 = 32'd4; #1;
    chk("beq_not_taken", next_pc, 32'h104);

    applyStimulus(32'h004100E7, 32'h20, 1);
    rrs1 = 32'h203; #1;
    chk("jalr_next_pc", next_pc, 32'h206);
    chk("jalr_result", result, 32'h24);
    chk("jalr_wr_regfile", 32'(wr_regfile), 32'd1);

    applyStimulus(32'hFE20AE23, 32'h60, 0);
    rrs1 = 32'h1000; rrs2 = 32'hAB; exec_req = 1'b1; #1;
    chk("sw_wr_mem", 32'(wr_mem), 32'd1);
    chk("sw_addr", wr_mem_addr, 32'hFFC);
    chk("sw_data", wr_mem_data, 32'hAB);
    chk("sw_wr_regfile", 32'(wr_regfile), 32'd0);
    chk("sw_rd_mem", 32'(rd_mem), 32'd0);
    exec_req = 1'b0; #1;
    chk("sw_wr_mem_idle", 32'(wr_mem), 32'd0);
    chk("sw_addr_idle", wr_mem_addr, 32'hFFC);

    applyStimulus(32'h0000006F, 32'hFFFFFFFC, 0);
    #1;
    chk("pc_wrap_result", result, 32'd0);

    // requester gives up mid-read: the read drains and no fetch_fin appears
    @(negedge clk);
    pc = 32'h200; fetch_req = 1'b1;
    @(negedge clk);
    chk("abort_rd_req", 32'(sdram_rd_req), 32'd1);
    fetch_req = 1'b0;
    repeat (2) @(negedge clk);
    sdram_rd_fin = 1'b1; sdram_rd_data = 32'h00A00113;
    @(negedge clk);
    sdram_rd_fin = 1'b0;
    chk("abort_fin", 32'(fetch_fin), 32'd0);
    chk("abort_rd_req_fall", 32'(sdram_rd_req), 32'd0);
    @(negedge clk);
    chk("abort_fin_later", 32'(fetch_fin), 32'd0);
    applyStimulus(32'h00A00113, 32'h300, 1);

    // reset during a read discards the completing data
    pc = 32'h80; fetch_req = 1'b1;
    @(negedge clk);
    reset = 1'b0; sdram_rd_fin = 1'b1; sdram_rd_data = 32'hDEADBEEF;
    @(negedge clk);
    reset = 1'b1; sdram_rd_fin = 1'b0; fetch_req = 1'b0;
    chk("midrst_instr", instr, 32'h00000013);
    chk("midrst_fin", 32'(fetch_fin), 32'd0);
    chk("midrst_rd_req", 32'(sdram_rd_req), 32'd0);
    chk("midrst_rd_addr", sdram_rd_addr, 32'd0);
    @(negedge clk);
    chk("midrst_fin_later", 32'(fetch_fin), 32'd0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom;
      ins = {r[31:7], opc_table[$urandom_range(0, 10)][6:0]};
      if ($urandom_range(0, 7) == 0) pcv = 32'hFFFFFFFC;
      else                           pcv = $urandom & 32'hFFFFFFFC;
      applyStimulus(ins, pcv, $urandom_range(0, 3));
      checkOutput(ins, pcv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
